// File: rtl/vga_sprite_pkg.sv
// Shared definitions for the sprite motion controller: FSM states and sprite-core register offsets.
// SPRITE_MOTION_ANIM_EN adds the animation-frame write state.
package vga_sprite_pkg;

    localparam int         REG_SEL  = 13;
    localparam logic [1:0] OFS_X0   = 2'd1;
    localparam logic [1:0] OFS_Y0   = 2'd2;
    localparam logic [1:0] OFS_CTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WR_X,
        ST_WR_Y
`ifdef SPRITE_MOTION_ANIM_EN
        , ST_WR_CTRL
`endif
    } motion_state_e;

    function automatic logic [13:0] core_reg_addr(input logic [1:0] ofs);
        core_reg_addr = 14'(1 << REG_SEL) | {12'd0, ofs};
    endfunction

endpackage

// File: rtl/sprite_bounce_calc.sv
// One-axis sprite step: adds velocity to position, clamps at 0 / limit and
// reverses velocity when the sprite would leave the visible area.
module sprite_bounce_calc (
    input  logic        [10:0] pos,
    input  logic signed [7:0]  vel,
    input  logic        [10:0] limit,
    output logic        [10:0] next_pos,
    output logic signed [7:0]  next_vel
);

    logic signed [11:0] sum;

    always_comb begin
        sum      = $signed({1'b0, pos}) + $signed({{4{vel[7]}}, vel});
        next_pos = sum[10:0];
        next_vel = vel;
        if (!vel[7] && (vel != 8'sd0) && (sum > $signed({1'b0, limit}))) begin
            next_pos = limit;
            next_vel = -vel;
        end else if (vel[7] && sum[11]) begin
            next_pos = 11'd0;
            next_vel = -vel;
        end
    end

endmodule

// File: rtl/vga_sprite_motion_ctrl.sv
// Moves a sprite once per frame at vertical blank and writes the new position to the sprite core,
// yielding the shared video slot to the CPU. SPRITE_MOTION_ANIM_EN adds periodic animation-frame writes.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting for the vblank trigger
// ST_CALC    | register next position/velocity for both axes
// ST_WR_X    | write x0 to the sprite core (stalls while cpu_cs)
// ST_WR_Y    | write y0 to the sprite core (stalls while cpu_cs)
// ST_WR_CTRL | write animation frame index (anim build only)
module vga_sprite_motion_ctrl
    import vga_sprite_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPR_W    = 32,
    parameter int SPR_H    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        cpu_cs,
    input  logic        cpu_write,
    input  logic [13:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    input  logic        ctl_cs,
    output logic        cs,
    output logic        write,
    output logic [13:0] addr,
    output logic [31:0] wr_data,
    output logic        busy
);

    localparam logic [10:0] X_LIMIT = 11'(H_ACTIVE - SPR_W);
    localparam logic [10:0] Y_LIMIT = 11'(V_ACTIVE - SPR_H);
    localparam logic [10:0] VB_LINE = 11'(V_ACTIVE);

    motion_state_e      state, state_next;
    logic               enable;
    logic signed [7:0]  vx, vy, calc_vx, calc_vy;
    logic        [10:0] pos_x, pos_y, calc_x, calc_y;
    logic               vb_hit, vb_hit_q, trigger;
    logic               ctl_wr, snoop_x, snoop_y;
    logic               eng_req;
    logic        [13:0] eng_addr;
    logic        [31:0] eng_data;

`ifdef SPRITE_MOTION_ANIM_EN
    logic [7:0] anim_period, anim_cnt;
    logic       anim_due;
    logic [2:0] frame_idx;
`endif

    // Edge-qualified so a frame counter that dwells on (0, V_ACTIVE) fires once
    assign vb_hit  = (x == 11'd0) && (y == VB_LINE);
    assign trigger = enable && vb_hit && !vb_hit_q && (state == ST_IDLE);
    assign ctl_wr  = ctl_cs && cpu_write;
    assign snoop_x = cpu_cs && cpu_write && (cpu_addr == core_reg_addr(OFS_X0));
    assign snoop_y = cpu_cs && cpu_write && (cpu_addr == core_reg_addr(OFS_Y0));
    assign busy    = (state != ST_IDLE);

    sprite_bounce_calc u_calc_x (
        .pos(pos_x), .vel(vx), .limit(X_LIMIT), .next_pos(calc_x), .next_vel(calc_vx)
    );

    sprite_bounce_calc u_calc_y (
        .pos(pos_y), .vel(vy), .limit(Y_LIMIT), .next_pos(calc_y), .next_vel(calc_vy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            enable   <= 1'b0;
            vx       <= '0;
            vy       <= '0;
            pos_x    <= '0;
            pos_y    <= '0;
            vb_hit_q <= 1'b0;
`ifdef SPRITE_MOTION_ANIM_EN
            anim_period <= '0;
            anim_cnt    <= '0;
            anim_due    <= 1'b0;
            frame_idx   <= '0;
`endif
        end else begin
            state    <= state_next;
            vb_hit_q <= vb_hit;
            if (state == ST_CALC) begin
                pos_x <= calc_x;
                pos_y <= calc_y;
                vx    <= calc_vx;
                vy    <= calc_vy;
            end
            // CPU writes land after the computed update so they take precedence
            if (ctl_wr) begin
                case (cpu_addr[1:0])
                    2'd0: enable <= cpu_wr_data[0];
                    2'd1: vx     <= cpu_wr_data[7:0];
                    2'd2: vy     <= cpu_wr_data[7:0];
`ifdef SPRITE_MOTION_ANIM_EN
                    2'd3: anim_period <= cpu_wr_data[7:0];
`endif
                    default: ;
                endcase
            end
            if (snoop_x) pos_x <= cpu_wr_data[10:0];
            if (snoop_y) pos_y <= cpu_wr_data[10:0];
`ifdef SPRITE_MOTION_ANIM_EN
            if (trigger) begin
                if ((anim_period != 8'd0) && (anim_cnt + 8'd1 == anim_period)) begin
                    anim_cnt <= '0;
                    anim_due <= 1'b1;
                end else begin
                    anim_cnt <= anim_cnt + 8'd1;
                end
            end
            if ((state == ST_WR_CTRL) && !cpu_cs) begin
                frame_idx <= frame_idx + 3'd1;
                anim_due  <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        state_next = state;
        eng_req    = 1'b0;
        eng_addr   = '0;
        eng_data   = '0;
        case (state)
            ST_IDLE: if (trigger) state_next = ST_CALC;
            ST_CALC: state_next = ST_WR_X;
            ST_WR_X: begin
                eng_req  = 1'b1;
                eng_addr = core_reg_addr(OFS_X0);
                eng_data = {21'd0, pos_x};
                if (!cpu_cs) state_next = ST_WR_Y;
            end
            ST_WR_Y: begin
                eng_req  = 1'b1;
                eng_addr = core_reg_addr(OFS_Y0);
                eng_data = {21'd0, pos_y};
`ifdef SPRITE_MOTION_ANIM_EN
                if (!cpu_cs) state_next = anim_due ? ST_WR_CTRL : ST_IDLE;
`else
                if (!cpu_cs) state_next = ST_IDLE;
`endif
            end
`ifdef SPRITE_MOTION_ANIM_EN
            ST_WR_CTRL: begin
                eng_req  = 1'b1;
                eng_addr = core_reg_addr(OFS_CTRL);
                eng_data = {27'd0, 2'b00, frame_idx + 3'd1};
                if (!cpu_cs) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        cs      = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        if (cpu_cs) begin
            cs      = 1'b1;
            write   = cpu_write;
            addr    = cpu_addr;
            wr_data = cpu_wr_data;
        end else if (eng_req) begin
            cs      = 1'b1;
            write   = 1'b1;
            addr    = eng_addr;
            wr_data = eng_data;
        end
    end

endmodule
